get_token_ring: RTL and testbench
=================================

# get_token_ring

Get-side controller for the FIR block's token-ring mixed-clock FIFO, running entirely in the `clk_get` domain. It circulates a one-hot get token across DEPTH FIFO cells. When the cell holding the token is full, it moves that cell's data into a single output register, pulses the cell's clear line, and advances the token. This block is the reader counterpart of the put-side token registers that fill the cells.

## Interface
Parameters:
- DEPTH, 4, number of FIFO cells / ring positions (≥2)
- WIDTH, 16, data bits per cell

Ports:
- clk_get  in  1  get-domain clock; all state on rising edge
- init_n  in  1  synchronous, active-low reset
- enable  in  1  global enable; low freezes all state
- hold  in  1  freezes token and capture; output register may still drain
- cell_full  in  DEPTH  per-cell full flags, already synchronized to clk_get
- cell_data  in  DEPTH*WIDTH  cell contents; cell i at bits [i*WIDTH +: WIDTH]
- get_req  in  1  consumer accepts get_data this cycle
- get_valid  out  1  output register holds a word (gated by enable)
- get_data  out  WIDTH  output register contents
- cell_clr  out  DEPTH  one-cycle pulse; clears the consumed cell's full flag
- tok_get  out  DEPTH  current one-hot token position
- empty  out  1  cell under the token is not full
- tok_err  out  1  sticky ring-corruption flag (present only with GET_TOK_ERR_EN)

## Operation
- Reset (init_n=0 at an edge) sets: tok_get=1 (cell 0); get_valid=0; get_data=0; cell_clr=0.
  - While init_n=0: empty=1, with tok_err=0 when that port is present.
  - Reset mid-transfer discards the output word. The cell that was read is not cleared.
- empty = ~|(tok_get & cell_full), combinational. Forced to 1 while init_n=0.
- out_free = ~valid_q | get_req.
- capture = enable & ~hold & ~empty & out_free.
- On capture:
  - valid_q←1.
  - get_data←cell_data of the token cell.
  - cell_clr[token]=1 for exactly this cycle (registered, visible the cycle after the edge).
  - Token rotates left; position DEPTH-1 wraps to 0.
- Drain (enable & get_req & valid_q & ~capture): valid_q←0. get_data keeps its value.
- Simultaneous drain and capture: valid_q stays 1 and get_data is replaced, giving back-to-back throughput.
- get_valid = valid_q & enable. A transfer occurs only when get_valid & get_req.
- hold=1:
  - Token, capture and cell_clr are suppressed.
  - A drain is still allowed.
- enable=0:
  - No capture and no drain.
  - Token, valid_q and get_data are retained.
  - get_valid reads 0.
- get_req while get_valid=0 is ignored.

## Timing
- Latency: cell full sampled at edge t → get_valid=1 after edge t.
  - cell_clr pulse is visible during the same cycle as that get_valid.
- Throughput: one word per cycle while cells are full and get_req is held high.
- The token advances at most one position per cycle.
- The put side must not refill a cell in the same cycle as its cell_clr pulse.
- All outputs except empty are registered or are an AND of a register with enable.

## Configuration
- GET_TOK_ERR_EN defined:
  - The tok_err port and a one-hot checker are built.
  - If popcount(tok_get)≠1 at an edge: tok_err←1 (sticky until reset), and the token reloads to cell 0 at that edge.
  - Capture is suppressed in the same cycle as the error.
- GET_TOK_ERR_EN not defined:
  - No tok_err port and no checker.
  - A corrupted token is left uncorrected.

## Structure
- Shared package `fir_tok_pkg` holds:
  - DEPTH/WIDTH default constants;
  - the token reset value constant (cell 0);
  - a one-hot check function used when GET_TOK_ERR_EN is defined.
- Sub-module `get_tok_cell`, instanced DEPTH times. Each instance holds:
  - one token flop, loaded from its left neighbour on capture, reset value 1 for cell 0 only;
  - its capture-enable AND;
  - its cell_clr flop.
- The top level holds the output register, the empty reduction and the optional checker.

## Test plan
- Reset, then cell_full=4'b0001, cell_data[0]=16'hA5A5, get_req=0 → next cycle: get_valid=1, get_data=A5A5, cell_clr=0001, tok_get=0010. The word is held until get_req.
- All four cells full with data 1,2,3,4, get_req held 1 → get_data = 1,2,3,4 on consecutive cycles. tok_get wraps to 0001. Then empty=1 and get_valid drops one cycle after the last word.
- Output register full, get_req=0, cell 1 full → no capture, cell_clr=0, token stays at cell 1. Raise get_req → drain and capture in the same cycle, get_valid stays 1.
- hold=1 with cells full and get_req=1 → the existing word drains, tok_get is unchanged, no cell_clr. Release hold → capture resumes next cycle.
- enable=0 mid-stream → get_valid=0 and state is frozen. Re-enable → the same word reappears with no loss or duplication.
- Reset asserted in the cycle after a capture → get_valid=0, tok_get=0001. With GET_TOK_ERR_EN, force tok_get=0110 → tok_err=1, token reloaded to 0001.

Source files
------------

// File: rtl/fir_tok_pkg.sv
// ============================================================================
// Module  : fir_tok_pkg
// Brief   : Shared constants and helpers for the FIR token-ring FIFO.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package fir_tok_pkg;

  localparam int c_DEPTH_DEF     = 4;
  localparam int c_WIDTH_DEF     = 16;
  // Ring position that holds the token after reset or reload.
  localparam int c_TOK_RESET_IDX = 0;
  // Widest ring the one-hot checker accepts.
  localparam int c_TOK_MAX       = 64;

  function automatic logic tok_is_onehot(input logic [c_TOK_MAX-1:0] tok);
    return ($countones(tok) == 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/get_token_ring_if.sv
// ============================================================================
// Module  : get_token_ring_if
// Brief   : Cell-side and consumer-side signals of the get token ring.
//           tok_err exists only when GET_TOK_ERR_EN is defined.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

interface get_token_ring_if
  import fir_tok_pkg::*;
#(
  parameter int DEPTH = c_DEPTH_DEF,
  parameter int WIDTH = c_WIDTH_DEF
);

  logic                   enable;
  logic                   hold;
  logic [DEPTH-1:0]       cell_full;
  logic [DEPTH*WIDTH-1:0] cell_data;
  logic                   get_req;
  logic                   get_valid;
  logic [WIDTH-1:0]       get_data;
  logic [DEPTH-1:0]       cell_clr;
  logic [DEPTH-1:0]       tok_get;
  logic                   empty;
`ifdef GET_TOK_ERR_EN
  logic                   tok_err;
`endif

  modport master (
    input  enable, hold, cell_full, cell_data, get_req,
    output get_valid, get_data, cell_clr, tok_get, empty
`ifdef GET_TOK_ERR_EN
    , output tok_err
`endif
  );

  modport slave (
    output enable, hold, cell_full, cell_data, get_req,
    input  get_valid, get_data, cell_clr, tok_get, empty
`ifdef GET_TOK_ERR_EN
    , input tok_err
`endif
  );

endinterface

`default_nettype wire

// File: rtl/get_tok_cell.sv
// ============================================================================
// Module  : get_tok_cell
// Brief   : One ring position: token flop, capture-enable gate, clear pulse.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module get_tok_cell
  import fir_tok_pkg::*;
#(
  parameter bit RESET_TOK = 1'b0
) (
  input  wire logic clk_get,
  input  wire logic init_n,
  input  wire logic i_tok_left,
  input  wire logic i_capture,
  input  wire logic i_reload,
  output logic      o_tok,
  output logic      o_clr
);

  logic r_tok;
  logic r_clr;
  logic w_take;

  assign w_take = i_capture & r_tok;

  always_ff @(posedge clk_get) begin
    if (!init_n) begin
      r_tok <= RESET_TOK;
      r_clr <= 1'b0;
    end else begin
      r_clr <= w_take;
      if (i_reload) begin
        r_tok <= RESET_TOK;
      end else if (i_capture) begin
        r_tok <= i_tok_left;
      end
    end
  end

  assign o_tok = r_tok;
  assign o_clr = r_clr;

endmodule

`default_nettype wire

// File: rtl/get_token_ring.sv
// ============================================================================
// Module  : get_token_ring
// Brief   : Get-side token ring controller; moves the token cell's word into
//           an output register. Optional macro GET_TOK_ERR_EN adds a sticky
//           one-hot checker (tok_err) that reloads a corrupted token.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module get_token_ring
  import fir_tok_pkg::*;
#(
  parameter int DEPTH = c_DEPTH_DEF,
  parameter int WIDTH = c_WIDTH_DEF
) (
  input  wire logic         clk_get,
  input  wire logic         init_n,
  get_token_ring_if.master  bus
);

  logic [DEPTH-1:0] w_tok;
  logic [DEPTH-1:0] w_clr;
  logic [WIDTH-1:0] w_sel_data;
  logic             w_empty;
  logic             w_out_free;
  logic             w_capture;
  logic             w_drain;
  logic             w_tok_bad;
  logic             r_valid;
  logic [WIDTH-1:0] r_data;

  assign w_empty    = ~init_n | ~|(w_tok & bus.cell_full);
  assign w_out_free = ~r_valid | bus.get_req;
  assign w_capture  = bus.enable & ~bus.hold & ~w_empty & w_out_free & ~w_tok_bad;
  assign w_drain    = bus.enable & bus.get_req & r_valid & ~w_capture;

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_cell
      localparam int c_LEFT = (gi == 0) ? DEPTH - 1 : gi - 1;
      get_tok_cell #(
        .RESET_TOK (gi == c_TOK_RESET_IDX)
      ) u_cell (
        .clk_get    (clk_get),
        .init_n     (init_n),
        .i_tok_left (w_tok[c_LEFT]),
        .i_capture  (w_capture),
        .i_reload   (w_tok_bad),
        .o_tok      (w_tok[gi]),
        .o_clr      (w_clr[gi])
      );
    end
  endgenerate

  // AND-OR select; the token is one-hot whenever a capture is allowed.
  always_comb begin
    w_sel_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (w_tok[i]) begin
        w_sel_data = w_sel_data | bus.cell_data[i*WIDTH +: WIDTH];
      end
    end
  end

  always_ff @(posedge clk_get) begin
    if (!init_n) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (w_capture) begin
      r_valid <= 1'b1;
      r_data  <= w_sel_data;
    end else if (w_drain) begin
      r_valid <= 1'b0;
    end
  end

`ifdef GET_TOK_ERR_EN
  logic [c_TOK_MAX-1:0] w_tok_ext;
  logic                 r_tok_err;

  always_comb begin
    w_tok_ext            = '0;
    w_tok_ext[DEPTH-1:0] = w_tok;
  end

  assign w_tok_bad = ~tok_is_onehot(w_tok_ext);

  always_ff @(posedge clk_get) begin
    if (!init_n) begin
      r_tok_err <= 1'b0;
    end else if (w_tok_bad) begin
      r_tok_err <= 1'b1;
    end
  end

  assign bus.tok_err = r_tok_err & init_n;
`else
  assign w_tok_bad = 1'b0;
`endif

  assign bus.get_valid = r_valid & bus.enable;
  assign bus.get_data  = r_data;
  assign bus.cell_clr  = w_clr;
  assign bus.tok_get   = w_tok;
  assign bus.empty     = w_empty;

endmodule

`default_nettype wire

// File: tb/tb_get_token_ring.sv
// ============================================================================
// Module  : tb_get_token_ring
// Brief   : Self-checking bench for get_token_ring (vector table, random
//           stimulus against a reference model, GET_TOK_ERR_EN sequence).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_get_token_ring;
  import fir_tok_pkg::*;

  localparam int DEPTH = 4;
  localparam int WIDTH = 16;

  logic clk_get = 1'b0;
  logic init_n  = 1'b0;
  always #5 clk_get = ~clk_get;

  get_token_ring_if #(.DEPTH(DEPTH), .WIDTH(WIDTH)) bus();

  get_token_ring #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clk_get (clk_get),
    .init_n  (init_n),
    .bus     (bus)
  );

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic        rstn, en, hl, req;
    logic [3:0]  full;
    logic [63:0] data;
    logic        exp_empty, exp_valid;
    logic [15:0] exp_data;
    logic [3:0]  exp_clr, exp_tok;
  } vec_t;

  vec_t vecs[20];

  // Reference state: token index, output register, last clear pulse.
  int          m_tok;
  logic        m_valid;
  logic [15:0] m_data;
  logic [3:0]  m_clr;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic rstn, input logic en, input logic hl, input logic req,
                       input logic [3:0] full, input logic [63:0] data);
    init_n        = rstn;
    bus.enable    = en;
    bus.hold      = hl;
    bus.get_req   = req;
    bus.cell_full = full;
    bus.cell_data = data;
  endtask

  function automatic vec_t mk(input logic rstn, input logic en, input logic hl, input logic req,
                              input logic [3:0] full, input logic [63:0] data,
                              input logic e_empty, input logic e_valid, input logic [15:0] e_data,
                              input logic [3:0] e_clr, input logic [3:0] e_tok);
    vec_t v;
    v.rstn = rstn; v.en = en; v.hl = hl; v.req = req; v.full = full; v.data = data;
    v.exp_empty = e_empty; v.exp_valid = e_valid; v.exp_data = e_data;
    v.exp_clr = e_clr; v.exp_tok = e_tok;
    return v;
  endfunction

  // Spec-level behaviour of one clock edge given the currently driven inputs.
  task automatic model_step();
    logic [15:0] words[4];
    bit          cap;
    for (int i = 0; i < DEPTH; i++) words[i] = bus.cell_data[i*WIDTH +: WIDTH];
    if (!init_n) begin
      m_tok = 0; m_valid = 1'b0; m_data = '0; m_clr = '0;
    end else begin
      cap   = bus.enable && !bus.hold && bus.cell_full[m_tok] && (!m_valid || bus.get_req);
      m_clr = '0;
      if (cap) begin
        m_clr[m_tok] = 1'b1;
        m_data       = words[m_tok];
        m_valid      = 1'b1;
        m_tok        = (m_tok + 1) % DEPTH;
      end else if (bus.enable && bus.get_req && m_valid) begin
        m_valid = 1'b0;
      end
    end
  endtask

  initial begin
    logic [63:0] d4;
    logic [63:0] dr;
    logic        r_rstn, r_en, r_hl, r_req;
    logic [3:0]  r_full;
    logic [3:0]  e_tok;

    d4 = 64'h0004_0003_0002_0001;
    vecs[0]  = mk(0,1,0,0,4'h0,64'h0,                      1,0,16'h0000,4'h0,4'h1);
    vecs[1]  = mk(1,1,0,0,4'h1,64'h0000_0000_0000_A5A5,    0,1,16'hA5A5,4'h1,4'h2);
    vecs[2]  = mk(1,1,0,0,4'h0,64'h0000_0000_0000_A5A5,    1,1,16'hA5A5,4'h0,4'h2);
    vecs[3]  = mk(1,1,0,0,4'h2,64'h0000_0000_1111_0000,    0,1,16'hA5A5,4'h0,4'h2);
    vecs[4]  = mk(1,1,0,1,4'h2,64'h0000_0000_1111_0000,    0,1,16'h1111,4'h2,4'h4);
    vecs[5]  = mk(1,1,0,1,4'h0,64'h0000_0000_1111_0000,    1,0,16'h1111,4'h0,4'h4);
    vecs[6]  = mk(0,1,0,0,4'h0,64'h0,                      1,0,16'h0000,4'h0,4'h1);
    vecs[7]  = mk(1,1,0,1,4'hF,d4,                         0,1,16'h0001,4'h1,4'h2);
    vecs[8]  = mk(1,1,0,1,4'hF,d4,                         0,1,16'h0002,4'h2,4'h4);
    vecs[9]  = mk(1,1,0,1,4'hF,d4,                         0,1,16'h0003,4'h4,4'h8);
    vecs[10] = mk(1,1,0,1,4'hF,d4,                         0,1,16'h0004,4'h8,4'h1);
    vecs[11] = mk(1,1,0,1,4'h0,d4,                         1,0,16'h0004,4'h0,4'h1);
    vecs[12] = mk(1,1,0,0,4'h1,64'h0000_0000_0000_00AA,    0,1,16'h00AA,4'h1,4'h2);
    vecs[13] = mk(1,1,1,1,4'hF,d4,                         0,0,16'h00AA,4'h0,4'h2);
    vecs[14] = mk(1,1,0,1,4'hF,d4,                         0,1,16'h0002,4'h2,4'h4);
    vecs[15] = mk(1,0,0,1,4'hF,d4,                         0,0,16'h0002,4'h0,4'h4);
    vecs[16] = mk(1,0,0,1,4'hF,d4,                         0,0,16'h0002,4'h0,4'h4);
    vecs[17] = mk(1,1,0,0,4'hF,d4,                         0,1,16'h0002,4'h0,4'h4);
    vecs[18] = mk(1,1,0,1,4'hF,d4,                         0,1,16'h0003,4'h4,4'h8);
    vecs[19] = mk(0,1,0,0,4'hF,d4,                         1,0,16'h0000,4'h0,4'h1);

    drive(0, 0, 0, 0, 4'h0, 64'h0);
    @(posedge clk_get); #1;

    // Directed table: empty checked before the edge, the rest after it.
    for (int i = 0; i < 20; i++) begin
      drive(vecs[i].rstn, vecs[i].en, vecs[i].hl, vecs[i].req, vecs[i].full, vecs[i].data);
      #1;
      chk($sformatf("vec%0d_empty", i), bus.empty, vecs[i].exp_empty);
      @(posedge clk_get); #1;
      chk($sformatf("vec%0d_valid", i), bus.get_valid, vecs[i].exp_valid);
      chk($sformatf("vec%0d_data", i),  bus.get_data,  vecs[i].exp_data);
      chk($sformatf("vec%0d_clr", i),   bus.cell_clr,  vecs[i].exp_clr);
      chk($sformatf("vec%0d_tok", i),   bus.tok_get,   vecs[i].exp_tok);
    end

    // Randomized run against the reference model, starting from reset.
    drive(0, 1, 0, 0, 4'h0, 64'h0);
    model_step();
    @(posedge clk_get); #1;
    for (int n = 0; n < 400; n++) begin
      r_rstn = ($urandom_range(0, 39) != 0);
      r_en   = ($urandom_range(0, 7) != 0);
      r_hl   = ($urandom_range(0, 5) == 0);
      r_req  = ($urandom_range(0, 1) == 1);
      r_full = 4'($urandom_range(0, 15));
      dr     = {$urandom(), $urandom()};
      drive(r_rstn, r_en, r_hl, r_req, r_full, dr);
      #1;
      chk("rand_empty", bus.empty, (!init_n || !bus.cell_full[m_tok]));
      model_step();
      @(posedge clk_get); #1;
      e_tok = 4'(1 << m_tok);
      chk("rand_valid", bus.get_valid, m_valid & bus.enable);
      chk("rand_data",  bus.get_data,  m_data);
      chk("rand_clr",   bus.cell_clr,  m_clr);
      chk("rand_tok",   bus.tok_get,   e_tok);
    end

`ifdef GET_TOK_ERR_EN
    drive(0, 1, 0, 0, 4'hF, d4);
    @(posedge clk_get); #1;
    chk("err_in_reset", bus.tok_err, 1'b0);
    drive(1, 1, 0, 1, 4'hF, d4);
    force dut.w_tok = 4'b0110;
    @(posedge clk_get); #1;
    release dut.w_tok;
    #1;
    chk("err_flag",     bus.tok_err,   1'b1);
    chk("err_reload",   bus.tok_get,   4'h1);
    chk("err_no_clr",   bus.cell_clr,  4'h0);
    chk("err_no_cap",   bus.get_valid, 1'b0);
    @(posedge clk_get); #1;
    chk("err_sticky",   bus.tok_err,   1'b1);
    chk("err_resume",   bus.get_data,  16'h0001);
    chk("err_tok_next", bus.tok_get,   4'h2);
    drive(0, 1, 0, 0, 4'h0, 64'h0);
    @(posedge clk_get); #1;
    chk("err_cleared",  bus.tok_err,   1'b0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
